// File: rtl/axi_arb_pkg.sv
// rtl/axi_arb_pkg.sv - shared types and helpers for the AXI response/address arbiters
//
// Purpose: common width helper and the B-channel beat layout used by the
// arbiter family. No ports (package).
package axi_arb_pkg;

  // $clog2 that never returns 0, so a single-input arbiter still gets a
  // 1-bit select/pointer instead of a zero-width vector.
  function automatic int clog2_min1(input int n);
    return ($clog2(n) > 0) ? $clog2(n) : 1;
  endfunction

  localparam int B_RESP_WIDTH     = 2;
  localparam int B_ID_WIDTH_DEF   = 4;
  localparam int B_USER_WIDTH_DEF = 1;

  typedef struct packed {
    logic [B_ID_WIDTH_DEF-1:0]   id;
    logic [B_USER_WIDTH_DEF-1:0] user;
    logic [B_RESP_WIDTH-1:0]     resp;
  } b_beat_t;

  localparam int B_BEAT_WIDTH = $bits(b_beat_t);

endpackage

// File: rtl/rr_arb_core.sv
// rtl/rr_arb_core.sv - combinational round-robin request picker
//
// Purpose: given a request vector and a rotating start pointer, pick the
// first requester at or after ptr (wrapping).
// Ports:
//   req       in   NUM_IN      request per input
//   ptr       in   SEL_WIDTH   highest-priority input index this cycle
//   grant     out  NUM_IN      one-hot winner, zero when no request
//   grant_idx out  SEL_WIDTH   index of the winner (0 when none)
//   any       out  1           at least one request present
module rr_arb_core
  import axi_arb_pkg::*;
#(
  parameter  int NUM_IN    = 4,
  localparam int SEL_WIDTH = clog2_min1(NUM_IN)
) (
  input  logic [NUM_IN-1:0]    req,
  input  logic [SEL_WIDTH-1:0] ptr,
  output logic [NUM_IN-1:0]    grant,
  output logic [SEL_WIDTH-1:0] grant_idx,
  output logic                 any
);

  // Walk the inputs in rotated order starting at ptr; the first hit wins.
  // The modulo maps the rotated position back to the physical index, which
  // folds rotate, priority-find and unrotate into one loop.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    for (int k = 0; k < NUM_IN; k++) begin
      logic [SEL_WIDTH-1:0] idx;
      idx = SEL_WIDTH'((int'(ptr) + k) % NUM_IN);
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant_idx  = idx;
        grant[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_b_rr_arbiter.sv
// rtl/axi_b_rr_arbiter.sv - round-robin merge of NUM_IN AXI B channels onto one
//
// Purpose: fair arbitration of write responses with one registered output
// stage (1-cycle latency, full throughput) and a source index per beat.
// Ports:
//   clk_i, rst_i     clock; synchronous active-high reset
//   slave_valid_i    per-input BVALID
//   slave_resp_i     per-input BRESP, input i at [2i+1:2i]
//   slave_id_i       per-input BID, packed likewise
//   slave_user_i     per-input BUSER, packed likewise
//   slave_ready_o    per-input BREADY (only ever to the current winner)
//   master_valid_o   merged BVALID
//   master_resp_o    merged BRESP
//   master_id_o      merged BID
//   master_user_o    merged BUSER
//   master_sel_o     input index that sourced the current beat
//   master_ready_i   upstream BREADY
module axi_b_rr_arbiter
  import axi_arb_pkg::*;
#(
  parameter  int NUM_IN     = 4,
  parameter  int ID_WIDTH   = 4,
  parameter  int USER_WIDTH = 1,
  localparam int SEL_WIDTH  = clog2_min1(NUM_IN)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NUM_IN-1:0]            slave_valid_i,
  input  logic [NUM_IN*B_RESP_WIDTH-1:0] slave_resp_i,
  input  logic [NUM_IN*ID_WIDTH-1:0]   slave_id_i,
  input  logic [NUM_IN*USER_WIDTH-1:0] slave_user_i,
  output logic [NUM_IN-1:0]            slave_ready_o,
  output logic                         master_valid_o,
  output logic [B_RESP_WIDTH-1:0]      master_resp_o,
  output logic [ID_WIDTH-1:0]          master_id_o,
  output logic [USER_WIDTH-1:0]        master_user_o,
  output logic [SEL_WIDTH-1:0]         master_sel_o,
  input  logic                         master_ready_i
);

  logic [B_RESP_WIDTH-1:0] resp_arr [NUM_IN];
  logic [ID_WIDTH-1:0]     id_arr   [NUM_IN];
  logic [USER_WIDTH-1:0]   user_arr [NUM_IN];

  for (genvar g = 0; g < NUM_IN; g++) begin : g_unpack
    assign resp_arr[g] = slave_resp_i[g*B_RESP_WIDTH +: B_RESP_WIDTH];
    assign id_arr[g]   = slave_id_i[g*ID_WIDTH +: ID_WIDTH];
    assign user_arr[g] = slave_user_i[g*USER_WIDTH +: USER_WIDTH];
  end

  logic [SEL_WIDTH-1:0] rr_ptr;
  logic [NUM_IN-1:0]    grant;
  logic [SEL_WIDTH-1:0] grant_idx;
  logic                 any;
  logic                 load_en;

  rr_arb_core #(
    .NUM_IN(NUM_IN)
  ) u_core (
    .req      (slave_valid_i),
    .ptr      (rr_ptr),
    .grant    (grant),
    .grant_idx(grant_idx),
    .any      (any)
  );

  // The output register may take a new beat when it is empty or is being
  // drained this cycle, so a stall upstream never loses or skips a beat.
  assign load_en = !master_valid_o || master_ready_i;

  // Ready is suppressed during reset so no source believes it handed off a
  // response that the reset is about to discard.
  assign slave_ready_o = (rst_i || !load_en) ? '0 : grant;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      master_valid_o <= 1'b0;
      master_resp_o  <= '0;
      master_id_o    <= '0;
      master_user_o  <= '0;
      master_sel_o   <= '0;
      rr_ptr         <= '0;
    end else if (load_en) begin
      if (any) begin
        master_valid_o <= 1'b1;
        master_resp_o  <= resp_arr[grant_idx];
        master_id_o    <= id_arr[grant_idx];
        master_user_o  <= user_arr[grant_idx];
        master_sel_o   <= grant_idx;
        // Pointer moves just past the winner, and only on a grant, so idle
        // cycles do not disturb the rotation.
        rr_ptr <= (grant_idx == SEL_WIDTH'(NUM_IN - 1)) ? '0 : grant_idx + 1'b1;
      end else begin
        master_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi_b_rr_arbiter.sv
// tb/tb_axi_b_rr_arbiter.sv - self-checking bench for axi_b_rr_arbiter
module tb_axi_b_rr_arbiter;

  localparam int N = 4;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic [N-1:0]   slave_valid_i;
  logic [2*N-1:0] slave_resp_i;
  logic [4*N-1:0] slave_id_i;
  logic [N-1:0]   slave_user_i;
  logic [N-1:0]   slave_ready_o;
  logic           master_valid_o;
  logic [1:0]     master_resp_o;
  logic [3:0]     master_id_o;
  logic [0:0]     master_user_o;
  logic [1:0]     master_sel_o;
  logic           master_ready_i;

  logic [1:0] in_resp [N];
  logic [3:0] in_id   [N];
  logic       in_user [N];

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign slave_resp_i[2*g +: 2] = in_resp[g];
    assign slave_id_i[4*g +: 4]   = in_id[g];
    assign slave_user_i[g]        = in_user[g];
  end

  axi_b_rr_arbiter #(
    .NUM_IN    (N),
    .ID_WIDTH  (4),
    .USER_WIDTH(1)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .slave_valid_i (slave_valid_i),
    .slave_resp_i  (slave_resp_i),
    .slave_id_i    (slave_id_i),
    .slave_user_i  (slave_user_i),
    .slave_ready_o (slave_ready_o),
    .master_valid_o(master_valid_o),
    .master_resp_o (master_resp_o),
    .master_id_o   (master_id_o),
    .master_user_o (master_user_o),
    .master_sel_o  (master_sel_o),
    .master_ready_i(master_ready_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [1:0] resp;
    logic [3:0] id;
    logic       user;
    logic [1:0] sel;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  bit   mon_on = 1'b0;

  function automatic exp_t beat_of(input int i);
    exp_t r;
    r.resp = in_resp[i];
    r.id   = in_id[i];
    r.user = in_user[i];
    r.sel  = 2'(i);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Output side of the scoreboard: every cycle the output valid must match
  // model occupancy, and a held beat must match the oldest expected entry.
  task automatic scoreboard_monitor();
    forever begin
      @(negedge clk_i);
      if (mon_on) begin
        checks++;
        if (master_valid_o !== (sb.size() > 0)) begin
          errors++;
          $display("FAIL out_valid: got %b want %b", master_valid_o, sb.size() > 0);
        end else if (master_valid_o) begin
          checks++;
          if ({master_resp_o, master_id_o, master_user_o, master_sel_o} !== sb[0]) begin
            errors++;
            $display("FAIL out_beat: got resp=%b id=%h user=%b sel=%0d want resp=%b id=%h user=%b sel=%0d",
                     master_resp_o, master_id_o, master_user_o, master_sel_o,
                     sb[0].resp, sb[0].id, sb[0].user, sb[0].sel);
          end
          if (master_ready_i) void'(sb.pop_front());
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    slave_valid_i = 4'hF;
    master_ready_i = 1'b1;
    tick();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk_i);
      checks++;
      if (master_valid_o !== 1'b0 || slave_ready_o !== 4'b0 || master_sel_o !== 2'd0) begin
        errors++;
        $display("FAIL reset_hold: got valid=%b ready=%b sel=%0d want 0/0000/0",
                 master_valid_o, slave_ready_o, master_sel_o);
      end
      tick();
    end
    rst_i = 1'b0;
    mon_on = 1'b1;
    @(negedge clk_i);
    checks++;
    if (master_valid_o !== 1'b0 || master_sel_o !== 2'd0) begin
      errors++;
      $display("FAIL reset_release_out: got valid=%b sel=%0d want 0/0", master_valid_o, master_sel_o);
    end
    checks++;
    if (slave_ready_o !== 4'b0001) begin
      errors++;
      $display("FAIL reset_release_ready: got %b want 0001", slave_ready_o);
    end
    tick();
    sb.push_back(beat_of(0));
    slave_valid_i = 4'h0;
  endtask

  task automatic test_fair_rotation();
    int cnt [N];
    logic [3:0] exp_rdy;
    for (int i = 0; i < N; i++) cnt[i] = 0;
    slave_valid_i = 4'hF;
    master_ready_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_i);
      exp_rdy = 4'b0001 << ((1 + k) % N);
      checks++;
      if (slave_ready_o !== exp_rdy) begin
        errors++;
        $display("FAIL rotation_ready[%0d]: got %b want %b", k, slave_ready_o, exp_rdy);
      end
      for (int i = 0; i < N; i++) if (slave_ready_o[i] === 1'b1) cnt[i]++;
      tick();
      sb.push_back(beat_of((1 + k) % N));
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (cnt[i] != 2) begin
        errors++;
        $display("FAIL rotation_share[%0d]: got %0d grants want 2", i, cnt[i]);
      end
    end
    slave_valid_i = 4'h0;
    @(negedge clk_i);
    checks++;
    if (slave_ready_o !== 4'b0) begin
      errors++;
      $display("FAIL rotation_idle_ready: got %b want 0000", slave_ready_o);
    end
    tick();
  endtask

  task automatic test_backpressure();
    in_resp[2] = 2'b10;
    in_id[2] = 4'h5;
    slave_valid_i = 4'b0100;
    master_ready_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (slave_ready_o !== 4'b0100) begin
      errors++;
      $display("FAIL bp_first_ready: got %b want 0100", slave_ready_o);
    end
    tick();
    sb.push_back(beat_of(2));
    in_id[2] = 4'h6;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i);
      checks++;
      if (slave_ready_o !== 4'b0) begin
        errors++;
        $display("FAIL bp_stall_ready[%0d]: got %b want 0000", c, slave_ready_o);
      end
      checks++;
      if (master_valid_o !== 1'b1 || master_resp_o !== 2'b10 || master_id_o !== 4'h5 || master_sel_o !== 2'd2) begin
        errors++;
        $display("FAIL bp_frozen[%0d]: got valid=%b resp=%b id=%h sel=%0d want 1/10/5/2",
                 c, master_valid_o, master_resp_o, master_id_o, master_sel_o);
      end
      tick();
    end
    master_ready_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (slave_ready_o !== 4'b0100) begin
      errors++;
      $display("FAIL bp_release_ready: got %b want 0100", slave_ready_o);
    end
    tick();
    sb.push_back(beat_of(2));
    slave_valid_i = 4'h0;
    in_id[2] = 4'hA;
    in_resp[2] = 2'b10;
    @(negedge clk_i);
    tick();
  endtask

  task automatic test_sparse();
    logic [3:0] vld [4];
    logic [3:0] rdy [4];
    int         win [4];
    vld = '{4'b0001, 4'b1001, 4'b0001, 4'b1111};
    rdy = '{4'b0001, 4'b1000, 4'b0001, 4'b0010};
    win = '{0, 3, 0, 1};
    for (int k = 0; k < 4; k++) begin
      slave_valid_i = vld[k];
      @(negedge clk_i);
      checks++;
      if (slave_ready_o !== rdy[k]) begin
        errors++;
        $display("FAIL sparse_ready[%0d]: got %b want %b", k, slave_ready_o, rdy[k]);
      end
      tick();
      sb.push_back(beat_of(win[k]));
    end
    slave_valid_i = 4'h0;
    @(negedge clk_i);
    tick();
  endtask

  task automatic test_reset_mid_stall();
    master_ready_i = 1'b0;
    slave_valid_i = 4'b0010;
    @(negedge clk_i);
    checks++;
    if (slave_ready_o !== 4'b0010) begin
      errors++;
      $display("FAIL rst_stall_grant: got %b want 0010", slave_ready_o);
    end
    tick();
    sb.push_back(beat_of(1));
    slave_valid_i = 4'hF;
    rst_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (slave_ready_o !== 4'b0) begin
      errors++;
      $display("FAIL rst_stall_ready: got %b want 0000", slave_ready_o);
    end
    tick();
    sb.delete();
    rst_i = 1'b0;
    master_ready_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (master_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_stall_dropped: got valid=%b want 0", master_valid_o);
    end
    checks++;
    if (slave_ready_o !== 4'b0001) begin
      errors++;
      $display("FAIL rst_stall_ptr: got %b want 0001", slave_ready_o);
    end
    tick();
    sb.push_back(beat_of(0));
    slave_valid_i = 4'h0;
    @(negedge clk_i);
    tick();
  endtask

  task automatic test_idle_bubble();
    slave_valid_i = 4'hF;
    master_ready_i = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk_i);
      checks++;
      if (slave_ready_o !== (4'b0010 << k)) begin
        errors++;
        $display("FAIL idle_pre_ready[%0d]: got %b want %b", k, slave_ready_o, 4'b0010 << k);
      end
      tick();
      sb.push_back(beat_of(1 + k));
    end
    slave_valid_i = 4'h0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      checks++;
      if (master_valid_o !== (c == 0)) begin
        errors++;
        $display("FAIL idle_valid[%0d]: got %b want %b", c, master_valid_o, c == 0);
      end
      tick();
    end
    slave_valid_i = 4'hF;
    @(negedge clk_i);
    checks++;
    if (slave_ready_o !== 4'b1000) begin
      errors++;
      $display("FAIL idle_ptr_held: got %b want 1000", slave_ready_o);
    end
    tick();
    sb.push_back(beat_of(3));
    slave_valid_i = 4'h0;
    @(negedge clk_i);
    checks++;
    if (master_valid_o !== 1'b1 || master_sel_o !== 2'd3) begin
      errors++;
      $display("FAIL idle_latency: got valid=%b sel=%0d want 1/3", master_valid_o, master_sel_o);
    end
    tick();
    @(negedge clk_i);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d beats outstanding want 0", sb.size());
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      in_resp[i] = 2'(i);
      in_id[i]   = 4'(8 + i);
      in_user[i] = i[0];
    end
    rst_i = 1'b1;
    slave_valid_i = '0;
    master_ready_i = 1'b0;
    fork
      scoreboard_monitor();
    join_none
    test_reset();
    test_fair_rotation();
    test_backpressure();
    test_sparse();
    test_reset_mid_stall();
    test_idle_bubble();
    mon_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
